shift_seq_ctrl: RTL and testbench

- Sequencer for a serial-in, WIDTH-bit left-shifting register, i.e. `{q[WIDTH-2:0], bit}` per enabled cycle.
- Accepts a parallel word over a valid/ready handshake and drives the register's shift enable and serial bit, MSB first, for exactly WIDTH shifts, with optional idle gap cycles between shifts.
- Afterwards captures the register's parallel output and presents it on a second valid/ready interface.
- Sits between the transaction source and the shift register; enables loopback checking of the shift path.

---
 rtl/shift_seq_pkg.sv | 16 +
 rtl/shift_seq_ctrl.sv | 119 +++++++++++
 tb/tb_shift_seq_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/shift_seq_pkg.sv
// Shared constants and state encoding for the shift-register sequencer.
// The default WIDTH/GAP values are shared with the shift register instance.
package shift_seq_pkg;

  localparam int WIDTH_DEF = 10;
  localparam int GAP_DEF   = 0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SHIFT   = 3'd1,
    ST_GAP     = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/shift_seq_ctrl.sv
// Sequences a parallel word MSB-first into an external left-shifting register,
// then captures the register's parallel output for the rx handshake.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int GAP   = GAP_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [WIDTH-1:0] tx_data,
  output logic             sr_shift_en,
  output logic             sr_bit,
  input  logic [WIDTH-1:0] sr_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q;
  logic [WIDTH-1:0] hold_q;
  logic [CNT_W-1:0] bitcnt_q;
  logic [3:0]       gapcnt_q;
  logic             tx_ready_q, sr_shift_en_q, sr_bit_q, rx_valid_q, busy_q;
  logic [WIDTH-1:0] rx_data_q;

  assign tx_ready    = tx_ready_q;
  assign sr_shift_en = sr_shift_en_q;
  assign sr_bit      = sr_bit_q;
  assign rx_valid    = rx_valid_q;
  assign rx_data     = rx_data_q;
  assign busy        = busy_q;

  // Outputs are loaded alongside the state transition so they describe the
  // state being entered; nothing combinational reaches a port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      hold_q        <= '0;
      bitcnt_q      <= '0;
      gapcnt_q      <= '0;
      tx_ready_q    <= 1'b1;
      sr_shift_en_q <= 1'b0;
      sr_bit_q      <= 1'b0;
      rx_valid_q    <= 1'b0;
      rx_data_q     <= '0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (tx_valid) begin
            hold_q        <= tx_data;
            bitcnt_q      <= CNT_W'(WIDTH - 1);
            state_q       <= ST_SHIFT;
            tx_ready_q    <= 1'b0;
            busy_q        <= 1'b1;
            sr_shift_en_q <= 1'b1;
            sr_bit_q      <= tx_data[WIDTH-1];
          end
        end
        ST_SHIFT: begin
          hold_q <= hold_q << 1;
          if (bitcnt_q == '0) begin
            state_q       <= ST_CAPTURE;
            sr_shift_en_q <= 1'b0;
            sr_bit_q      <= 1'b0;
          end else begin
            bitcnt_q <= bitcnt_q - CNT_W'(1);
            if (GAP > 0) begin
              state_q       <= ST_GAP;
              gapcnt_q      <= 4'(GAP - 1);
              sr_shift_en_q <= 1'b0;
              sr_bit_q      <= 1'b0;
            end else begin
              sr_bit_q <= hold_q[WIDTH-2];
            end
          end
        end
        ST_GAP: begin
          if (gapcnt_q == '0) begin
            state_q       <= ST_SHIFT;
            sr_shift_en_q <= 1'b1;
            sr_bit_q      <= hold_q[WIDTH-1];
          end else begin
            gapcnt_q <= gapcnt_q - 4'd1;
          end
        end
        ST_CAPTURE: begin
          // The register took its last bit on the edge that ended SHIFT.
          rx_data_q  <= sr_data;
          rx_valid_q <= 1'b1;
          state_q    <= ST_DONE;
        end
        ST_DONE: begin
          if (rx_ready) begin
            rx_valid_q <= 1'b0;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= ST_IDLE;
          end
        end
        default: begin
          state_q       <= ST_IDLE;
          tx_ready_q    <= 1'b1;
          sr_shift_en_q <= 1'b0;
          sr_bit_q      <= 1'b0;
          rx_valid_q    <= 1'b0;
          busy_q        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Loopback bench: two controllers (GAP=0 and GAP=2), each driving its own
// 10-bit shift register whose parallel output feeds back as sr_data.
module tb_shift_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // GAP=0 instance
  logic       txv0 = 0, txr0, en0, bit0, rxv0, rxr0 = 0, busy0;
  logic [9:0] txd0 = '0, rxd0, sr0_q;
  // GAP=2 instance
  logic       txv2 = 0, txr2, en2, bit2, rxv2, rxr2 = 0, busy2;
  logic [9:0] txd2 = '0, rxd2, sr2_q;

  shift_seq_ctrl #(.WIDTH(10), .GAP(0)) u0 (
    .clk(clk), .rst(rst), .tx_valid(txv0), .tx_ready(txr0), .tx_data(txd0),
    .sr_shift_en(en0), .sr_bit(bit0), .sr_data(sr0_q), .rx_valid(rxv0),
    .rx_ready(rxr0), .rx_data(rxd0), .busy(busy0));

  shift_seq_ctrl #(.WIDTH(10), .GAP(2)) u2 (
    .clk(clk), .rst(rst), .tx_valid(txv2), .tx_ready(txr2), .tx_data(txd2),
    .sr_shift_en(en2), .sr_bit(bit2), .sr_data(sr2_q), .rx_valid(rxv2),
    .rx_ready(rxr2), .rx_data(rxd2), .busy(busy2));

  always_ff @(posedge clk or posedge rst)
    if (rst) sr0_q <= '0;
    else if (en0) sr0_q <= {sr0_q[8:0], bit0};

  always_ff @(posedge clk or posedge rst)
    if (rst) sr2_q <= '0;
    else if (en2) sr2_q <= {sr2_q[8:0], bit2};

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(2);
    checks++; if (txr0 !== 1'b1) begin failures++; $display("FAIL reset_tx_ready got=%b exp=1", txr0); end
    checks++; if ({en0, bit0, rxv0, busy0} !== 4'b0) begin failures++; $display("FAIL reset_ctl got=%b exp=0000", {en0, bit0, rxv0, busy0}); end
    checks++; if (rxd0 !== 10'h000) begin failures++; $display("FAIL reset_rx_data got=%h exp=000", rxd0); end
    checks++; if ({txr2, en2, rxv2, busy2} !== 4'b1000) begin failures++; $display("FAIL reset_u2 got=%b exp=1000", {txr2, en2, rxv2, busy2}); end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_basic;
    logic [9:0] w;
    w = 10'h2A5;
    txv0 = 1; txd0 = w; rxr0 = 0;
    tick(1);
    txv0 = 0;
    for (int i = 0; i < 10; i++) begin
      checks++; if (en0 !== 1'b1) begin failures++; $display("FAIL basic_en cyc=%0d got=%b exp=1", i, en0); end
      checks++; if (bit0 !== w[9-i]) begin failures++; $display("FAIL basic_bit cyc=%0d got=%b exp=%b", i, bit0, w[9-i]); end
      checks++; if (txr0 !== 1'b0) begin failures++; $display("FAIL basic_tx_ready cyc=%0d got=%b exp=0", i, txr0); end
      tick(1);
    end
    checks++; if ({en0, rxv0, busy0} !== 3'b001) begin failures++; $display("FAIL basic_capture got=%b exp=001", {en0, rxv0, busy0}); end
    tick(1);
    checks++; if (rxv0 !== 1'b1) begin failures++; $display("FAIL basic_rx_valid got=%b exp=1", rxv0); end
    checks++; if (rxd0 !== 10'h2A5) begin failures++; $display("FAIL basic_rx_data got=%h exp=2a5", rxd0); end
    rxr0 = 1;
    tick(1);
    rxr0 = 0;
    checks++; if ({rxv0, txr0, busy0} !== 3'b010) begin failures++; $display("FAIL basic_idle got=%b exp=010", {rxv0, txr0, busy0}); end
  endtask

  task automatic test_gap;
    txv2 = 1; txd2 = 10'h3FF; rxr2 = 0;
    tick(1);
    txv2 = 0;
    for (int c = 0; c < 28; c++) begin
      checks++;
      if (en2 !== ((c % 3) == 0)) begin failures++; $display("FAIL gap_en cyc=%0d got=%b exp=%b", c, en2, (c % 3) == 0); end
      tick(1);
    end
    checks++; if ({en2, rxv2} !== 2'b00) begin failures++; $display("FAIL gap_capture got=%b exp=00", {en2, rxv2}); end
    tick(1);
    checks++; if (rxv2 !== 1'b1) begin failures++; $display("FAIL gap_rx_valid got=%b exp=1", rxv2); end
    checks++; if (rxd2 !== 10'h3FF) begin failures++; $display("FAIL gap_rx_data got=%h exp=3ff", rxd2); end
    rxr2 = 1;
    tick(1);
    rxr2 = 0;
    checks++; if ({rxv2, txr2} !== 2'b01) begin failures++; $display("FAIL gap_idle got=%b exp=01", {rxv2, txr2}); end
  endtask

  task automatic test_hold_valid;
    txv0 = 1; txd0 = 10'h1C3; rxr0 = 0;
    tick(1);
    txd0 = 10'h03C;
    for (int i = 0; i < 11; i++) begin
      checks++; if (txr0 !== 1'b0) begin failures++; $display("FAIL hold_tx_ready cyc=%0d got=%b exp=0", i, txr0); end
      tick(1);
    end
    checks++; if (rxv0 !== 1'b1 || txr0 !== 1'b0) begin failures++; $display("FAIL hold_done got=%b%b exp=10", rxv0, txr0); end
    checks++; if (rxd0 !== 10'h1C3) begin failures++; $display("FAIL hold_first_word got=%h exp=1c3", rxd0); end
    rxr0 = 1;
    tick(1);
    checks++; if ({rxv0, txr0} !== 2'b01) begin failures++; $display("FAIL hold_idle got=%b exp=01", {rxv0, txr0}); end
    tick(1);
    txv0 = 0;
    checks++; if ({busy0, txr0, en0} !== 3'b101) begin failures++; $display("FAIL hold_second_accept got=%b exp=101", {busy0, txr0, en0}); end
    tick(11);
    checks++; if (rxd0 !== 10'h03C || rxv0 !== 1'b1) begin failures++; $display("FAIL hold_second_word got=%h/%b exp=03c/1", rxd0, rxv0); end
    tick(1);
    checks++; if (rxv0 !== 1'b0) begin failures++; $display("FAIL hold_done_one_cycle got=%b exp=0", rxv0); end
    rxr0 = 0;
  endtask

  task automatic test_rx_stall;
    txv0 = 1; txd0 = 10'h001; rxr0 = 0;
    tick(1);
    txv0 = 0;
    tick(11);
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (rxv0 !== 1'b1 || rxd0 !== 10'h001 || txr0 !== 1'b0) begin
        failures++; $display("FAIL stall cyc=%0d got=%b/%h/%b exp=1/001/0", i, rxv0, rxd0, txr0);
      end
      tick(1);
    end
    rxr0 = 1;
    tick(1);
    rxr0 = 0;
    checks++; if ({rxv0, txr0, busy0} !== 3'b010) begin failures++; $display("FAIL stall_release got=%b exp=010", {rxv0, txr0, busy0}); end
  endtask

  task automatic test_reset_mid;
    txv0 = 1; txd0 = 10'h155;
    tick(1);
    txv0 = 0;
    tick(3);
    checks++; if (en0 !== 1'b1 || busy0 !== 1'b1) begin failures++; $display("FAIL rstmid_pre got=%b%b exp=11", en0, busy0); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({txr0, en0, bit0, rxv0, busy0} !== 5'b10000) begin failures++; $display("FAIL rstmid_async got=%b exp=10000", {txr0, en0, bit0, rxv0, busy0}); end
    checks++; if (rxd0 !== 10'h000) begin failures++; $display("FAIL rstmid_rx_data got=%h exp=000", rxd0); end
    tick(1);
    rst = 1'b0;
    tick(1);
    txv0 = 1; txd0 = 10'h0F0; rxr0 = 0;
    tick(1);
    txv0 = 0;
    tick(11);
    checks++; if (rxv0 !== 1'b1 || rxd0 !== 10'h0F0) begin failures++; $display("FAIL rstmid_fresh got=%b/%h exp=1/0f0", rxv0, rxd0); end
    rxr0 = 1;
    tick(1);
    rxr0 = 0;
  endtask

  task automatic test_back_to_back;
    txv0 = 1; txd0 = 10'h000; rxr0 = 1;
    tick(1);
    txd0 = 10'h3FF;
    tick(11);
    checks++; if (rxv0 !== 1'b1 || rxd0 !== 10'h000 || busy0 !== 1'b1) begin failures++; $display("FAIL b2b_first got=%b/%h/%b exp=1/000/1", rxv0, rxd0, busy0); end
    tick(1);
    checks++; if (busy0 !== 1'b0 || txr0 !== 1'b1) begin failures++; $display("FAIL b2b_gap got=%b%b exp=01", busy0, txr0); end
    tick(1);
    txv0 = 0;
    checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL b2b_rebusy got=%b exp=1", busy0); end
    tick(11);
    checks++; if (rxv0 !== 1'b1 || rxd0 !== 10'h3FF) begin failures++; $display("FAIL b2b_second got=%b/%h exp=1/3ff", rxv0, rxd0); end
    tick(1);
    checks++; if (busy0 !== 1'b0 || rxv0 !== 1'b0) begin failures++; $display("FAIL b2b_end got=%b%b exp=00", busy0, rxv0); end
    rxr0 = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gap();
    test_hold_valid();
    test_rx_stall();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
